// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the operator byte-entry block on the MAC transmit path.
package mac_tx_pkg;

    localparam int DEB_DEFAULT = 1_000_000;
    localparam int NIB_W       = 4;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        S_HI   = 2'd0,
        S_LO   = 2'd1,
        S_SEND = 2'd2
    } entry_state_t;

    // Switches are active-low; a closed switch reads as a 1 bit in the nibble.
    function automatic logic [NIB_W-1:0] nib_from_sw(input logic [NIB_W-1:0] sw_n);
        return ~sw_n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces the active-low commit key; emits a one-cycle press pulse
// on each accepted released-to-pressed transition.
module key_debounce
    import mac_tx_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int                CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_deb;
    logic             r_armed;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Until a stable release has been seen after reset, the counter only qualifies
    // the released level, so a key held through reset cannot generate a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_deb   <= 1'b1;
            r_armed <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= key_n;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (!r_armed) begin
                if (!r_s2) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_armed <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
            end else if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_deb   <= ~r_deb;
                r_cnt   <= '0;
                r_press <= r_deb;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/key_byte_entry.sv
// Two-nibble operator byte entry: high nibble then low nibble on debounced key presses,
// then the byte is offered to the MAC transmitter on a valid/ready handshake.
module key_byte_entry
    import mac_tx_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [NIB_W-1:0]  sw,
    input  logic              key_n,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              lec
);

    entry_state_t      r_state;
    entry_state_t      w_state_nxt;
    logic [NIB_W-1:0]  r_sw_s1;
    logic [NIB_W-1:0]  r_sw_s2;
    logic [NIB_W-1:0]  r_hi;
    logic [NIB_W-1:0]  w_hi_nxt;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] w_data_nxt;
    logic              r_tx_valid;
    logic              w_valid_nxt;
    logic              r_lec;
    logic              w_lec_nxt;
    logic              w_press;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (sys_clk),
        .rst   (rst),
        .key_n (key_n),
        .press (w_press)
    );

    // Switch synchronizer, FSM state and output registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_sw_s1    <= 4'hF;
            r_sw_s2    <= 4'hF;
            r_state    <= S_HI;
            r_hi       <= 4'h0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_lec      <= 1'b1;
        end else begin
            r_sw_s1    <= sw;
            r_sw_s2    <= r_sw_s1;
            r_state    <= w_state_nxt;
            r_hi       <= w_hi_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_lec      <= w_lec_nxt;
        end
    end

    // Next-state logic; presses arriving in S_SEND are deliberately ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_data_nxt  = r_tx_data;
        w_valid_nxt = r_tx_valid;
        w_lec_nxt   = r_lec;
        case (r_state)
            S_HI: begin
                if (w_press) begin
                    w_hi_nxt    = nib_from_sw(r_sw_s2);
                    w_lec_nxt   = 1'b0;
                    w_state_nxt = S_LO;
                end else begin
                    w_state_nxt = S_HI;
                end
            end
            S_LO: begin
                if (w_press) begin
                    w_data_nxt  = {r_hi, nib_from_sw(r_sw_s2)};
                    w_valid_nxt = 1'b1;
                    w_lec_nxt   = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_LO;
                end
            end
            S_SEND: begin
                if (r_tx_valid && tx_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_HI;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            default: begin
                w_state_nxt = S_HI;
                w_valid_nxt = 1'b0;
                w_lec_nxt   = 1'b1;
            end
        endcase
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign lec      = r_lec;

endmodule

// File: tb/tb_key_byte_entry.sv
// Directed self-checking bench for key_byte_entry with a short debounce window.
module tb_key_byte_entry;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       key_n;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       lec;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_bad;
    int first_hi;
    logic [7:0] seen_data;

    key_byte_entry #(.DEB_CYCLES(4)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .sw       (sw),
        .key_n    (key_n),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .lec      (lec)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (tx_valid) n_valid++;
    endtask

    task automatic press_key(input int n_low);
        key_n = 1'b0;
        repeat (n_low) tick();
        key_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic set_sw(input logic [3:0] nib);
        sw = ~nib;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; sw = 4'hF; key_n = 1'b1; tx_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_data", {24'd0, tx_data}, 32'h00);
        check_eq("rst_lec", {31'd0, lec}, 32'd1);
        rst = 1'b0;
        repeat (10) tick();

        // Clean entry A5 with ready already high
        tx_ready = 1'b1;
        set_sw(4'hA);
        press_key(6);
        check_eq("clean_lec_mid", {31'd0, lec}, 32'd0);
        check_eq("clean_valid_mid", {31'd0, tx_valid}, 32'd0);
        set_sw(4'h5);
        first_hi = -1; n_valid = 0; seen_data = 8'h00;
        key_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (tx_valid && first_hi < 0) begin
                first_hi  = i;
                seen_data = tx_data;
            end
            if (i == 6) key_n = 1'b1;
        end
        check_eq("clean_latency", first_hi, 32'd7);
        check_eq("clean_pulses", n_valid, 32'd1);
        check_eq("clean_data", {24'd0, seen_data}, 32'hA5);
        check_eq("clean_lec_end", {31'd0, lec}, 32'd1);
        repeat (4) tick();

        // Backpressure 3C
        tx_ready = 1'b0;
        set_sw(4'h3);
        press_key(6);
        set_sw(4'hC);
        press_key(6);
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!tx_valid || tx_data != 8'h3C) n_bad++;
        end
        check_eq("bp_stable", n_bad, 32'd0);
        tx_ready = 1'b1;
        tick();
        check_eq("bp_drop", {31'd0, tx_valid}, 32'd0);
        check_eq("bp_data_kept", {24'd0, tx_data}, 32'h3C);
        check_eq("bp_lec", {31'd0, lec}, 32'd1);
        tx_ready = 1'b0;

        // Bounce: no press, then a real press
        set_sw(4'h9);
        key_n = 1'b0; repeat (3) tick();
        key_n = 1'b1; tick();
        key_n = 1'b0; repeat (3) tick();
        key_n = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!lec) n_bad++;
        end
        check_eq("bounce_no_press", n_bad, 32'd0);
        press_key(6);
        check_eq("bounce_capture", {31'd0, lec}, 32'd0);
        set_sw(4'h6);
        press_key(6);
        check_eq("bounce_data", {24'd0, tx_data}, 32'h96);
        check_eq("bounce_valid", {31'd0, tx_valid}, 32'd1);

        // Press during S_SEND is dropped
        set_sw(4'hF);
        press_key(6);
        check_eq("send_data_held", {24'd0, tx_data}, 32'h96);
        check_eq("send_lec", {31'd0, lec}, 32'd1);
        tx_ready = 1'b1;
        tick();
        n_valid = 0;
        repeat (20) tick();
        check_eq("send_no_extra", n_valid, 32'd0);
        tx_ready = 1'b0;

        // Held key: one press only
        set_sw(4'h7);
        key_n = 1'b0;
        n_bad = 0; n_valid = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i >= 8 && lec) n_bad++;
        end
        key_n = 1'b1;
        repeat (8) tick();
        check_eq("held_lec_low", n_bad, 32'd0);
        check_eq("held_no_valid", n_valid, 32'd0);
        set_sw(4'h1);
        press_key(6);
        check_eq("held_data", {24'd0, tx_data}, 32'h71);

        // Reset during S_SEND
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_send_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_send_data", {24'd0, tx_data}, 32'h00);
        check_eq("rst_send_lec", {31'd0, lec}, 32'd1);
        repeat (10) tick();

        // Reset after high nibble, then fresh entry
        set_sw(4'hB);
        press_key(6);
        check_eq("rst_hi_lec0", {31'd0, lec}, 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_hi_lec1", {31'd0, lec}, 32'd1);
        repeat (10) tick();
        tx_ready = 1'b1;
        set_sw(4'hD);
        press_key(6);
        set_sw(4'h2);
        n_valid = 0;
        press_key(6);
        check_eq("fresh_pulses", n_valid, 32'd1);
        check_eq("fresh_data", {24'd0, tx_data}, 32'hD2);
        check_eq("fresh_valid_end", {31'd0, tx_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
